// File: rtl/loop_pkg.sv
// ----------------------------------------------------------------------------
// loop_pkg
// Shared definitions for the loop replay buffer slice.
//   lr_state_t         : replay buffer control state
//   INSTR_BYTES        : byte stride between consecutive loop instructions
//   LOOP_DEPTH_DEFAULT : default loop body capacity in instructions
// ----------------------------------------------------------------------------
package loop_pkg;

    typedef enum logic [1:0] {
        LR_IDLE    = 2'd0,
        LR_CAPTURE = 2'd1,
        LR_REPLAY  = 2'd2
    } lr_state_t;

    localparam int INSTR_BYTES        = 4;
    localparam int LOOP_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/loop_body_ram.sv
// ----------------------------------------------------------------------------
// loop_body_ram
// DEPTH x XLEN storage for one captured loop iteration.
// Synchronous write, combinational read, no reset on the array. The
// contents are only ever read after a complete fresh capture, so the
// storage needs no initial value.
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : instruction word to store
//   rd_addr : read index
//   rd_data : instruction word at rd_addr (combinational)
// ----------------------------------------------------------------------------
module loop_body_ram #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem_r [DEPTH];

    // Store one body instruction per accepted capture fetch.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/loop_replay_buffer.sv
// ----------------------------------------------------------------------------
// loop_replay_buffer
// Sits between fetch and decode, downstream of the loop detector. On a
// loop-start pulse it captures one iteration of the loop body as fetch
// delivers it, then replays that iteration from local storage (stalling
// fetch) until a mispredict flushes it. Outside replay it is a one-cycle
// registered pass-through of fetch to decode.
//
// Optional feature macro: LOOP_REPLAY_ITER_CNT_EN
//   defined   : replay_iters is a 16-bit saturating count of completed
//               replay iterations, cleared when a new capture starts
//   undefined : replay_iters is tied to zero
//
// Ports:
//   clk, reset (async, active-low)
//   loop_start, loop_start_pc, loop_len : loop detector interface
//   fetch_valid, fetch_pc, fetch_instr  : fetch stream
//   hold       : freeze outputs and pointers
//   mispredict : loop exit, returns to IDLE with priority
//   out_valid, out_pc, out_instr        : stream to decode
//   fetch_stall, replay_active          : high while replaying
//   capture_abort : one-cycle pulse when a capture is rejected/aborted
//   replay_iters  : completed replay iterations
// ----------------------------------------------------------------------------
module loop_replay_buffer
    import loop_pkg::*;
#(
    parameter int DEPTH = LOOP_DEPTH_DEFAULT,
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_start,
    input  logic [XLEN-1:0]  loop_start_pc,
    input  logic [CNT_W-1:0] loop_len,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [XLEN-1:0]  fetch_instr,
    input  logic             hold,
    input  logic             mispredict,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic             fetch_stall,
    output logic             replay_active,
    output logic             capture_abort,
    output logic [15:0]      replay_iters
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    // PC of body instruction idx, wrapping at XLEN bits.
    function automatic logic [XLEN-1:0] pc_at(input logic [XLEN-1:0] base,
                                              input logic [CNT_W-1:0] idx);
        return base + (XLEN'(idx) * XLEN'(INSTR_BYTES));
    endfunction

    lr_state_t        state_r;
    logic [XLEN-1:0]  start_pc_r;
    logic [CNT_W-1:0] loop_len_r;
    logic [CNT_W-1:0] wptr_r;
    logic [CNT_W-1:0] rptr_r;

    logic             len_ok_s;
    logic [XLEN-1:0]  exp_pc_s;
    logic             pc_match_s;
    logic             last_wr_s;
    logic             rptr_last_s;
    logic             wr_en_s;
    logic [XLEN-1:0]  rd_data_s;

    assign len_ok_s    = (loop_len != ZERO_C) && (loop_len <= DEPTH_C);
    assign exp_pc_s    = pc_at(start_pc_r, wptr_r);
    assign pc_match_s  = (fetch_pc == exp_pc_s);
    assign last_wr_s   = (wptr_r == (loop_len_r - ONE_C));
    assign rptr_last_s = (rptr_r == (loop_len_r - ONE_C));
    // A fetch is stored only when it is the next expected body instruction
    // and nothing of higher priority (mispredict, hold) claims the cycle.
    assign wr_en_s     = (state_r == LR_CAPTURE) && !mispredict && !hold &&
                         fetch_valid && pc_match_s;

    loop_body_ram #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_body_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wptr_r[AW-1:0]),
        .wr_data (fetch_instr),
        .rd_addr (rptr_r[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // Control FSM with registered decode-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= LR_IDLE;
            start_pc_r    <= {XLEN{1'b0}};
            loop_len_r    <= ZERO_C;
            wptr_r        <= ZERO_C;
            rptr_r        <= ZERO_C;
            out_valid     <= 1'b0;
            out_pc        <= {XLEN{1'b0}};
            out_instr     <= {XLEN{1'b0}};
            fetch_stall   <= 1'b0;
            replay_active <= 1'b0;
            capture_abort <= 1'b0;
        end else begin
            capture_abort <= 1'b0;
            if (mispredict) begin
                // Flush: one bubble to decode, leave replay next cycle.
                state_r       <= LR_IDLE;
                out_valid     <= 1'b0;
                fetch_stall   <= 1'b0;
                replay_active <= 1'b0;
                capture_abort <= (state_r == LR_CAPTURE);
            end else begin
                case (state_r)
                    LR_IDLE: begin
                        fetch_stall   <= 1'b0;
                        replay_active <= 1'b0;
                        if (!hold) begin
                            out_valid <= fetch_valid;
                            out_pc    <= fetch_pc;
                            out_instr <= fetch_instr;
                        end
                        if (loop_start) begin
                            if (len_ok_s) begin
                                start_pc_r <= loop_start_pc;
                                loop_len_r <= loop_len;
                                wptr_r     <= ZERO_C;
                                state_r    <= LR_CAPTURE;
                            end else begin
                                capture_abort <= 1'b1;
                            end
                        end
                    end
                    LR_CAPTURE: begin
                        if (!hold) begin
                            out_valid <= fetch_valid;
                            out_pc    <= fetch_pc;
                            out_instr <= fetch_instr;
                            if (fetch_valid) begin
                                if (pc_match_s) begin
                                    wptr_r <= wptr_r + ONE_C;
                                    if (last_wr_s) begin
                                        state_r       <= LR_REPLAY;
                                        rptr_r        <= ZERO_C;
                                        fetch_stall   <= 1'b1;
                                        replay_active <= 1'b1;
                                    end
                                end else begin
                                    // Fetch left the expected straight-line
                                    // body; the captured data is unusable.
                                    capture_abort <= 1'b1;
                                    state_r       <= LR_IDLE;
                                end
                            end
                        end
                    end
                    LR_REPLAY: begin
                        fetch_stall   <= 1'b1;
                        replay_active <= 1'b1;
                        if (!hold) begin
                            out_valid <= 1'b1;
                            out_pc    <= pc_at(start_pc_r, rptr_r);
                            out_instr <= rd_data_s;
                            if (rptr_last_s) begin
                                rptr_r <= ZERO_C;
                            end else begin
                                rptr_r <= rptr_r + ONE_C;
                            end
                        end
                    end
                    default: begin
                        state_r       <= LR_IDLE;
                        out_valid     <= 1'b0;
                        fetch_stall   <= 1'b0;
                        replay_active <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LOOP_REPLAY_ITER_CNT_EN
    logic        capture_enter_s;
    logic        wrap_s;
    logic [15:0] iters_r;

    assign capture_enter_s = (state_r == LR_IDLE) && !mispredict && loop_start && len_ok_s;
    assign wrap_s          = (state_r == LR_REPLAY) && !mispredict && !hold && rptr_last_s;

    // Saturating count of read-pointer wraps; restarts with each capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iters_r <= 16'd0;
        end else if (capture_enter_s) begin
            iters_r <= 16'd0;
        end else if (wrap_s && (iters_r != 16'hFFFF)) begin
            iters_r <= iters_r + 16'd1;
        end else begin
            iters_r <= iters_r;
        end
    end

    assign replay_iters = iters_r;
`else
    assign replay_iters = 16'd0;
`endif

endmodule

// File: tb/tb_loop_replay_buffer.sv
// ----------------------------------------------------------------------------
// tb_loop_replay_buffer
// Directed scenarios from the loop replay buffer behaviour, followed by a
// randomized run compared against a transaction-level reference model
// (captured body kept as a queue, replay position derived from the number
// of instructions emitted).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_loop_replay_buffer;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    logic             clk;
    logic             reset;
    logic             loop_start;
    logic [XLEN-1:0]  loop_start_pc;
    logic [CNT_W-1:0] loop_len;
    logic             fetch_valid;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  fetch_instr;
    logic             hold;
    logic             mispredict;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instr;
    logic             fetch_stall;
    logic             replay_active;
    logic             capture_abort;
    logic [15:0]      replay_iters;

    int checks = 0;
    int errors = 0;

    loop_replay_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .loop_start(loop_start), .loop_start_pc(loop_start_pc),
        .loop_len(loop_len), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .hold(hold), .mispredict(mispredict),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .fetch_stall(fetch_stall), .replay_active(replay_active),
        .capture_abort(capture_abort), .replay_iters(replay_iters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: mode 0 idle, 1 capturing, 2 replaying.
    // ------------------------------------------------------------------
    int          m_mode;
    logic [31:0] m_start;
    int          m_len;
    logic [31:0] m_body[$];
    int          m_emitted;
    logic        m_valid, m_stall, m_active, m_abort;
    logic [31:0] m_pc, m_instr;
    int          m_iters;

    task automatic model_reset();
        m_mode = 0; m_start = 32'h0; m_len = 0; m_body.delete(); m_emitted = 0;
        m_valid = 1'b0; m_stall = 1'b0; m_active = 1'b0; m_abort = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_iters = 0;
    endtask

    task automatic model_update();
        int idx;
        logic [31:0] exp_pc;
        m_abort = 1'b0;
        if (mispredict) begin
            if (m_mode == 1) m_abort = 1'b1;
            m_mode = 0; m_valid = 1'b0; m_stall = 1'b0; m_active = 1'b0;
        end else if (m_mode == 2) begin
            if (!hold) begin
                idx = m_emitted % m_len;
                m_pc = m_start + 32'(4 * idx);
                m_instr = m_body[idx];
                m_valid = 1'b1;
                m_emitted++;
                m_iters = (m_emitted / m_len > 65535) ? 65535 : m_emitted / m_len;
            end
        end else begin
            if (!hold) begin
                m_valid = fetch_valid; m_pc = fetch_pc; m_instr = fetch_instr;
            end
            if (m_mode == 0) begin
                if (loop_start) begin
                    if (loop_len >= 1 && int'(loop_len) <= DEPTH) begin
                        m_mode = 1; m_start = loop_start_pc; m_len = int'(loop_len);
                        m_body.delete(); m_iters = 0;
                    end else begin
                        m_abort = 1'b1;
                    end
                end
            end else if (!hold && fetch_valid) begin
                exp_pc = m_start + 32'(4 * m_body.size());
                if (fetch_pc == exp_pc) begin
                    m_body.push_back(fetch_instr);
                    if (m_body.size() == m_len) begin
                        m_mode = 2; m_emitted = 0; m_stall = 1'b1; m_active = 1'b1;
                    end
                end else begin
                    m_abort = 1'b1; m_mode = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        loop_start = 1'b0; loop_start_pc = 32'h0; loop_len = 5'd0;
        fetch_valid = 1'b0; fetch_pc = 32'h0; fetch_instr = 32'h0;
        hold = 1'b0; mispredict = 1'b0;
    endtask

    function automatic logic [15:0] iters_exp(input int n);
`ifdef LOOP_REPLAY_ITER_CNT_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n * 0);
`endif
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, fetch_stall, replay_active, capture_abort, replay_iters} !== 84'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pc=%h in=%h st=%b ra=%b ab=%b it=%0d expected all zero",
                     out_valid, out_pc, out_instr, fetch_stall, replay_active, capture_abort, replay_iters);
        end
        #3 reset = 1'b1;
    endtask

    task automatic test_pass_through();
        fetch_valid = 1'b1; fetch_pc = 32'h100; fetch_instr = 32'h13;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h13 || fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL pass_0: got v=%b pc=%h in=%h st=%b expected 1/100/13/0", out_valid, out_pc, out_instr, fetch_stall);
        end
        fetch_pc = 32'h104; fetch_instr = 32'h14;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_instr !== 32'h14 || fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL pass_1: got v=%b pc=%h in=%h st=%b expected 1/104/14/0", out_valid, out_pc, out_instr, fetch_stall);
        end
        fetch_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_invalid: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_capture_replay();
        logic [31:0] body [4];
        body[0] = 32'h13; body[1] = 32'h14; body[2] = 32'h15; body[3] = 32'hFC000AE3;
        loop_start = 1'b1; loop_start_pc = 32'h100; loop_len = 5'd4;
        step();
        loop_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1; fetch_pc = 32'h100 + 32'(4 * i); fetch_instr = body[i];
            step();
        end
        fetch_valid = 1'b0;
        checks++;
        if (replay_active !== 1'b1 || fetch_stall !== 1'b1 || capture_abort !== 1'b0) begin
            errors++;
            $display("FAIL cap_enter_replay: got ra=%b st=%b ab=%b expected 1/1/0", replay_active, fetch_stall, capture_abort);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * (k % 4)) || out_instr !== body[k % 4] || fetch_stall !== 1'b1) begin
                errors++;
                $display("FAIL replay_seq%0d: got v=%b pc=%h in=%h st=%b expected 1/%h/%h/1",
                         k, out_valid, out_pc, out_instr, fetch_stall, 32'h100 + 32'(4 * (k % 4)), body[k % 4]);
            end
        end
        checks++;
        if (replay_iters !== iters_exp(2)) begin
            errors++;
            $display("FAIL replay_iters: got %0d expected %0d", replay_iters, iters_exp(2));
        end
    endtask

    task automatic test_hold();
        repeat (3) step();
        checks++;
        if (out_pc !== 32'h108) begin
            errors++;
            $display("FAIL hold_setup: got pc=%h expected 108", out_pc);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_pc !== 32'h108 || out_instr !== 32'h15 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen%0d: got pc=%h in=%h v=%b expected 108/15/1", i, out_pc, out_instr, out_valid);
            end
        end
        hold = 1'b0;
        step();
        checks++;
        if (out_pc !== 32'h10C || out_instr !== 32'hFC000AE3) begin
            errors++;
            $display("FAIL hold_resume: got pc=%h in=%h expected 10c/fc000ae3", out_pc, out_instr);
        end
    endtask

    task automatic test_mispredict();
        repeat (2) step();
        checks++;
        if (out_pc !== 32'h104) begin
            errors++;
            $display("FAIL misp_setup: got pc=%h expected 104", out_pc);
        end
        mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || replay_active !== 1'b0 || fetch_stall !== 1'b0 || capture_abort !== 1'b0) begin
            errors++;
            $display("FAIL misp_flush: got v=%b ra=%b st=%b ab=%b expected 0/0/0/0", out_valid, replay_active, fetch_stall, capture_abort);
        end
        fetch_valid = 1'b1; fetch_pc = 32'h110; fetch_instr = 32'h16;
        step();
        fetch_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h110 || out_instr !== 32'h16) begin
            errors++;
            $display("FAIL misp_pass: got v=%b pc=%h in=%h expected 1/110/16", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_capture_abort();
        loop_start = 1'b1; loop_start_pc = 32'h110; loop_len = 5'd4;
        step();
        loop_start = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'h110; fetch_instr = 32'h20;
        step();
        checks++;
        if (capture_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_early: got ab=%b expected 0", capture_abort);
        end
        fetch_pc = 32'h200;
        step();
        fetch_valid = 1'b0;
        checks++;
        if (capture_abort !== 1'b1 || fetch_stall !== 1'b0 || replay_active !== 1'b0) begin
            errors++;
            $display("FAIL abort_pc: got ab=%b st=%b ra=%b expected 1/0/0", capture_abort, fetch_stall, replay_active);
        end
        step();
        checks++;
        if (capture_abort !== 1'b0 || fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got ab=%b st=%b expected 0/0", capture_abort, fetch_stall);
        end
        // Length outside 1..DEPTH is rejected at once.
        loop_start = 1'b1; loop_start_pc = 32'h110; loop_len = 5'd17;
        step();
        loop_start = 1'b0;
        checks++;
        if (capture_abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_len17: got ab=%b expected 1", capture_abort);
        end
        loop_start = 1'b1; loop_len = 5'd0;
        step();
        loop_start = 1'b0;
        checks++;
        if (capture_abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_len0: got ab=%b expected 1", capture_abort);
        end
        // Still IDLE: a fetch that would complete a capture passes through.
        fetch_valid = 1'b1; fetch_pc = 32'h110; fetch_instr = 32'h33;
        step();
        fetch_valid = 1'b0;
        checks++;
        if (capture_abort !== 1'b0 || replay_active !== 1'b0 || out_pc !== 32'h110) begin
            errors++;
            $display("FAIL abort_idle: got ab=%b ra=%b pc=%h expected 0/0/110", capture_abort, replay_active, out_pc);
        end
        // Mispredict during capture also aborts.
        loop_start = 1'b1; loop_start_pc = 32'h300; loop_len = 5'd2;
        step();
        loop_start = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'h300; fetch_instr = 32'h44;
        step();
        fetch_valid = 1'b0; mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        checks++;
        if (capture_abort !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_misp: got ab=%b v=%b expected 1/0", capture_abort, out_valid);
        end
        step();
    endtask

    task automatic test_async_reset();
        loop_start = 1'b1; loop_start_pc = 32'h400; loop_len = 5'd2;
        step();
        loop_start = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'h400; fetch_instr = 32'hA;
        step();
        fetch_pc = 32'h404; fetch_instr = 32'hB;
        step();
        fetch_valid = 1'b0;
        step();
        checks++;
        if (replay_active !== 1'b1 || out_pc !== 32'h400 || out_instr !== 32'hA) begin
            errors++;
            $display("FAIL areset_setup: got ra=%b pc=%h in=%h expected 1/400/a", replay_active, out_pc, out_instr);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, fetch_stall, replay_active, capture_abort, replay_iters} !== 84'h0) begin
            errors++;
            $display("FAIL areset_zero: got v=%b pc=%h in=%h st=%b ra=%b ab=%b it=%0d expected all zero",
                     out_valid, out_pc, out_instr, fetch_stall, replay_active, capture_abort, replay_iters);
        end
        #2 reset = 1'b1;
        step();
        checks++;
        if (replay_active !== 1'b0 || fetch_stall !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: got ra=%b st=%b v=%b expected 0/0/0", replay_active, fetch_stall, out_valid);
        end
    endtask

    task automatic test_random();
        int r;
        clear_inputs();
        mispredict = 1'b1;
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_inputs();
            r = $urandom_range(0, 99);
            fetch_instr = $urandom;
            if (m_mode == 0) begin
                if (r < 25) begin
                    loop_start = 1'b1;
                    case ($urandom_range(0, 9))
                        0:       loop_len = 5'd0;
                        1:       loop_len = 5'($urandom_range(17, 31));
                        2:       loop_len = 5'd16;
                        default: loop_len = 5'($urandom_range(1, 8));
                    endcase
                    loop_start_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                end else begin
                    hold = ($urandom_range(0, 7) == 0);
                    mispredict = (r > 96);
                end
                fetch_valid = $urandom_range(0, 1);
                fetch_pc = $urandom;
            end else if (m_mode == 1) begin
                fetch_valid = ($urandom_range(0, 3) != 0);
                hold = ($urandom_range(0, 7) == 0);
                mispredict = (r == 0);
                loop_start = ($urandom_range(0, 9) == 0);
                loop_len = 5'd3;
                fetch_pc = m_start + 32'(4 * m_body.size());
                if ($urandom_range(0, 39) == 0) fetch_pc = fetch_pc + 32'd8;
            end else begin
                fetch_valid = $urandom_range(0, 1);
                fetch_pc = $urandom;
                hold = ($urandom_range(0, 5) == 0);
                loop_start = ($urandom_range(0, 9) == 0);
                loop_len = 5'd2;
                mispredict = ($urandom_range(0, 40) == 0);
            end
            step();
            checks++;
            if (out_valid !== m_valid || out_pc !== m_pc || out_instr !== m_instr ||
                fetch_stall !== m_stall || replay_active !== m_active ||
                capture_abort !== m_abort || replay_iters !== iters_exp(m_iters)) begin
                errors++;
                $display("FAIL rand_cyc%0d: got v=%b pc=%h in=%h st=%b ra=%b ab=%b it=%0d expected v=%b pc=%h in=%h st=%b ra=%b ab=%b it=%0d",
                         cyc, out_valid, out_pc, out_instr, fetch_stall, replay_active, capture_abort, replay_iters,
                         m_valid, m_pc, m_instr, m_stall, m_active, m_abort, iters_exp(m_iters));
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_capture_replay();
        test_hold();
        test_mispredict();
        test_capture_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_replay_buffer.md
Name: loop_replay_buffer

Overview:
- Sits directly downstream of the loop detector, between fetch and decode.
- On the detector's loop-start pulse, captures one full iteration of the loop body as it is fetched.
- Then replays that iteration from local storage, stalling fetch, until a mispredict (loop exit) flushes it.
- Outside replay it is a one-cycle registered pass-through of fetch to decode.

Parameters:
- DEPTH, 16, maximum loop body length in instructions (power of two, ≥2)
- XLEN, 32, width of PC and instruction words
- CNT_W, $clog2(DEPTH)+1, width of loop_len and internal counters

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- loop_start  input  1  one-cycle pulse from the loop detector: loop confirmed
- loop_start_pc  input  XLEN  PC of the first loop instruction (backward-branch target)
- loop_len  input  CNT_W  body length in instructions, including the branch
- fetch_valid  input  1  fetch_pc/fetch_instr valid this cycle
- fetch_pc  input  XLEN  PC from fetch
- fetch_instr  input  XLEN  instruction from fetch
- hold  input  1  ID/EX bubble: freeze outputs and replay pointer
- mispredict  input  1  loop-exit/mispredict from EX
- out_valid  output  1  out_pc/out_instr valid
- out_pc  output  XLEN  PC to decode
- out_instr  output  XLEN  instruction to decode
- fetch_stall  output  1  high while replaying; fetch must not advance
- replay_active  output  1  state == REPLAY
- capture_abort  output  1  one-cycle pulse: capture rejected or aborted
- replay_iters  output  16  completed replay iterations (see Optional Feature)

Behaviour:
- Reset (reset==0, async): state IDLE; out_valid=0, out_pc=0, out_instr=0, fetch_stall=0, replay_active=0, capture_abort=0, replay_iters=0; pointers cleared.
- State IDLE:
  - Pass-through with 1-cycle latency: out_* <= fetch_*, out_valid <= fetch_valid.
  - loop_start with 1≤loop_len≤DEPTH: latch loop_start_pc and loop_len, wptr=0 -> CAPTURE.
  - loop_start with loop_len==0 or loop_len>DEPTH: pulse capture_abort, stay IDLE.
- State CAPTURE:
  - Pass-through continues unchanged.
  - Each fetch_valid cycle: check fetch_pc == start_pc + 4*wptr.
  - On match: write fetch_instr to mem[wptr], wptr++.
  - On mismatch: pulse capture_abort -> IDLE.
  - When the write of index loop_len-1 completes -> REPLAY, rptr=0.
- State REPLAY:
  - fetch_stall=1, replay_active=1.
  - Each cycle with hold==0: out_instr <= mem[rptr], out_pc <= start_pc + 4*rptr (XLEN-bit wrap), out_valid <= 1.
  - rptr wraps from loop_len-1 to 0; each wrap increments the iteration count.
- hold==1 in any state: out_*, rptr and wptr frozen; CAPTURE ignores fetch that cycle.
- mispredict (any state) has priority over loop_start, hold and capture progress:
  - Next state IDLE; out_valid <= 0 for one cycle.
  - fetch_stall and replay_active deassert the following cycle.
  - From CAPTURE, also pulse capture_abort.
- loop_start while in CAPTURE or REPLAY is ignored.
- Storage holds no valid contents across IDLE; every entry into REPLAY is preceded by a fresh capture.

Optional Feature:
- Macro: LOOP_REPLAY_ITER_CNT_EN.
- Defined:
  - replay_iters is a 16-bit saturating count of completed replay iterations (rptr wrap events).
  - Cleared on entry to CAPTURE; holds its value in IDLE until the next capture.
- Undefined: replay_iters is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package loop_pkg:
  - State enum lr_state_t {LR_IDLE, LR_CAPTURE, LR_REPLAY}.
  - Constants INSTR_BYTES=4 and LOOP_DEPTH_DEFAULT=16.
- One sub-module, loop_body_ram: DEPTH x XLEN storage, synchronous write, combinational read, no reset on the array.

Test Plan:
- Pass-through: IDLE, fetch 0x100/0x13 then 0x104/0x14 -> out matches one cycle later; fetch_stall=0.
- Capture and replay: loop_start, start_pc=0x100, len=4; fetch 0x100:0x13, 0x104:0x14, 0x108:0x15, 0x10C:0xFC000AE3.
  - Expect replay_active=1 the next cycle.
  - Output sequence 0x100,0x104,0x108,0x10C,0x100… with matching instructions; fetch_stall=1.
  - replay_iters=2 after 8 replayed cycles.
- Hold: during replay, hold=1 for 3 cycles at out_pc=0x108 -> outputs frozen; resumes at 0x10C.
- Mispredict: mid-replay at out_pc=0x104 -> next cycle out_valid=0, state IDLE; then fetch 0x110/0x16 passes through.
- Capture abort:
  - len=4, start 0x110, second fetch at 0x200 -> capture_abort pulse, IDLE, no stall.
  - len=17 (DEPTH=16) -> immediate capture_abort.
- Async reset: assert reset low mid-replay between clock edges -> all outputs 0 immediately; IDLE after release.
